// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master issues divides and flushes; the slave reports busy and the results.
interface div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, op_signed, dividend, divisor, flush,
        input  busy, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  start, op_signed, dividend, divisor, flush,
        output busy, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, zero-divisor results returned immediately.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   abs_dividend, abs_divisor;
    logic [WIDTH:0]     diff;

    always_comb begin
        abs_dividend = (bus.op_signed && bus.dividend[WIDTH-1]) ? (WIDTH'(0) - bus.dividend) : bus.dividend;
        abs_divisor  = (bus.op_signed && bus.divisor[WIDTH-1])  ? (WIDTH'(0) - bus.divisor)  : bus.divisor;
        // Upper half after the shift needs WIDTH+1 bits: the bit shifted out of the MSB is kept.
        diff = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};

        state_d     = state_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        out_valid_d = 1'b0;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dz_d        = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d      = '1;
                        rem_d       = bus.dividend;
                        dz_d        = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        work_d  = {{WIDTH{1'b0}}, abs_dividend};
                        dvs_d   = abs_divisor;
                        cnt_d   = '0;
                        q_neg_d = bus.op_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_d = bus.op_signed & bus.dividend[WIDTH-1];
                    end
                end
            end
            S_DIV: begin
                if (!diff[WIDTH]) begin
                    work_d = {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_d = {work_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quot_d      = q_neg_q ? (WIDTH'(0) - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
                rem_d       = r_neg_q ? (WIDTH'(0) - work_q[2*WIDTH-1:WIDTH]) : work_q[2*WIDTH-1:WIDTH];
                dz_d        = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything, including a same-cycle start or completion.
        if (bus.flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            quot_d      = quot_q;
            rem_d       = rem_q;
            dz_d        = dz_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule
